// File: rtl/writeback_unit.sv
// writeback_unit: MEM/WB stage of the 16-bit pipeline. It selects the ALU
// result or the load data, stalls while a load response is outstanding, and
// drives the register file write port from registers.
module writeback_unit #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 3,
    parameter bit ZERO_PROTECT = 1'b1,
    parameter int LOAD_TIMEOUT = 15,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic              wb_reg_write,
    input  logic              wb_mem_to_reg,
    input  logic [ADDR_W-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_alu_result,
    input  logic              mem_rdata_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              write_EN,
    output logic [ADDR_W-1:0] reg_write_add,
    output logic [DATA_W-1:0] reg_write_data,
    output logic              load_pending,
    output logic [ADDR_W-1:0] pending_add,
    output logic [CNT_W-1:0]  retire_count,
    output logic              load_timeout
);

    localparam int TIMER_W = $clog2(LOAD_TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(LOAD_TIMEOUT - 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT_LOAD
    } state_t;

    state_t              state_q, state_d;
    logic                write_en_q, write_en_d;
    logic [ADDR_W-1:0]   reg_write_add_q, reg_write_add_d;
    logic [DATA_W-1:0]   reg_write_data_q, reg_write_data_d;
    logic [ADDR_W-1:0]   pending_add_q, pending_add_d;
    logic                pend_wr_ok_q, pend_wr_ok_d;
    logic [CNT_W-1:0]    retire_count_q, retire_count_d;
    logic                load_timeout_q, load_timeout_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;

    logic accept;
    logic wr_ok;

    assign wb_ready = (state_q == S_IDLE);
    assign accept   = wb_valid && wb_ready;
    // r0 is hard-wired zero in the register file, so writes to it are dropped.
    assign wr_ok    = wb_reg_write && !(ZERO_PROTECT && (wb_dest == '0));

    // Next-state and registered write-port values for both states.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d          = state_q;
        write_en_d       = 1'b0;
        reg_write_add_d  = reg_write_add_q;
        reg_write_data_d = reg_write_data_q;
        pending_add_d    = pending_add_q;
        pend_wr_ok_d     = pend_wr_ok_q;
        retire_count_d   = retire_count_q;
        load_timeout_d   = load_timeout_q;
        timer_d          = timer_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (wb_reg_write && wb_mem_to_reg) begin
                        // Load: remember where it goes, then wait for data.
                        pending_add_d = wb_dest;
                        pend_wr_ok_d  = wr_ok;
                        timer_d       = '0;
                        state_d       = S_WAIT_LOAD;
                    end else begin
                        write_en_d     = wr_ok;
                        retire_count_d = retire_count_q + CNT_W'(1);
                        if (wr_ok) begin
                            reg_write_add_d  = wb_dest;
                            reg_write_data_d = wb_alu_result;
                        end
                    end
                end
            end
            S_WAIT_LOAD: begin
                if (mem_rdata_valid) begin
                    // Data on the final timeout cycle still completes the load.
                    write_en_d     = pend_wr_ok_q;
                    retire_count_d = retire_count_q + CNT_W'(1);
                    if (pend_wr_ok_q) begin
                        reg_write_add_d  = pending_add_q;
                        reg_write_data_d = mem_rdata;
                    end
                    pending_add_d = '0;
                    state_d       = S_IDLE;
                end else if (timer_q == TIMER_LAST) begin
                    // Response never came: drop the load and flag it.
                    load_timeout_d = 1'b1;
                    pending_add_d  = '0;
                    state_d        = S_IDLE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q          <= S_IDLE;
            write_en_q       <= 1'b0;
            reg_write_add_q  <= '0;
            reg_write_data_q <= '0;
            pending_add_q    <= '0;
            pend_wr_ok_q     <= 1'b0;
            retire_count_q   <= '0;
            load_timeout_q   <= 1'b0;
            timer_q          <= '0;
        end else begin
            state_q          <= state_d;
            write_en_q       <= write_en_d;
            reg_write_add_q  <= reg_write_add_d;
            reg_write_data_q <= reg_write_data_d;
            pending_add_q    <= pending_add_d;
            pend_wr_ok_q     <= pend_wr_ok_d;
            retire_count_q   <= retire_count_d;
            load_timeout_q   <= load_timeout_d;
            timer_q          <= timer_d;
        end
    end

    assign write_EN       = write_en_q;
    assign reg_write_add  = reg_write_add_q;
    assign reg_write_data = reg_write_data_q;
    assign load_pending   = (state_q == S_WAIT_LOAD);
    assign pending_add    = pending_add_q;
    assign retire_count   = retire_count_q;
    assign load_timeout   = load_timeout_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Testbench for writeback_unit: expected register writes go into a
// scoreboard queue as stimulus is driven and are popped as write_EN pulses.
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic        wb_ready;
    logic        wb_reg_write;
    logic        wb_mem_to_reg;
    logic [2:0]  wb_dest;
    logic [15:0] wb_alu_result;
    logic        mem_rdata_valid;
    logic [15:0] mem_rdata;
    logic        write_EN;
    logic [2:0]  reg_write_add;
    logic [15:0] reg_write_data;
    logic        load_pending;
    logic [2:0]  pending_add;
    logic [15:0] retire_count;
    logic        load_timeout;

    int n_cmp = 0;
    int n_err = 0;
    int exp_retire = 0;
    logic [18:0] sb[$];

    writeback_unit dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_dest(wb_dest), .wb_alu_result(wb_alu_result),
        .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
        .write_EN(write_EN), .reg_write_add(reg_write_add),
        .reg_write_data(reg_write_data), .load_pending(load_pending),
        .pending_add(pending_add), .retire_count(retire_count),
        .load_timeout(load_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard consumer: every write pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (write_EN === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_write", 32'(reg_write_add), 32'hFFFF_FFFF);
            end else begin
                logic [18:0] e;
                e = sb.pop_front();
                check("wr_add", 32'(reg_write_add), 32'(e[18:16]));
                check("wr_data", 32'(reg_write_data), 32'(e[15:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [2:0] d, input logic [15:0] v);
        wb_valid = 1'b1; wb_reg_write = 1'b1; wb_mem_to_reg = 1'b0;
        wb_dest = d; wb_alu_result = v;
        if (d != 3'd0) sb.push_back({d, v});
        exp_retire++;
        tick();
        wb_valid = 1'b0; wb_reg_write = 1'b0;
    endtask

    task automatic load_start(input logic [2:0] d);
        wb_valid = 1'b1; wb_reg_write = 1'b1; wb_mem_to_reg = 1'b1; wb_dest = d;
        tick();
        wb_valid = 1'b0; wb_reg_write = 1'b0; wb_mem_to_reg = 1'b0;
    endtask

    task automatic load_resp(input logic [2:0] d, input logic [15:0] v);
        mem_rdata_valid = 1'b1; mem_rdata = v;
        if (d != 3'd0) sb.push_back({d, v});
        exp_retire++;
        tick();
        mem_rdata_valid = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_wen"},   32'(write_EN), 0);
        check({tag, "_add"},   32'(reg_write_add), 0);
        check({tag, "_data"},  32'(reg_write_data), 0);
        check({tag, "_pend"},  32'(load_pending), 0);
        check({tag, "_padd"},  32'(pending_add), 0);
        check({tag, "_ret"},   32'(retire_count), 0);
        check({tag, "_tmo"},   32'(load_timeout), 0);
        check({tag, "_ready"}, 32'(wb_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wb_valid = 1'b0; wb_reg_write = 1'b0; wb_mem_to_reg = 1'b0;
        wb_dest = '0; wb_alu_result = '0; mem_rdata_valid = 1'b0; mem_rdata = '0;
        tick(); tick();
        rst = 1'b0;
        check_reset_state("reset");

        // Back-to-back ALU writes.
        alu(3'd1, 16'h1234);
        check("b2b_wen1", 32'(write_EN), 1);
        alu(3'd2, 16'hBEEF);
        check("b2b_wen2", 32'(write_EN), 1);
        tick();
        check("b2b_wen_off", 32'(write_EN), 0);
        check("b2b_retire", 32'(retire_count), 2);

        // ALU write to r0 is suppressed but still retires; port holds values.
        alu(3'd0, 16'h5555);
        check("r0_wen", 32'(write_EN), 0);
        check("r0_hold_add", 32'(reg_write_add), 2);
        check("r0_hold_data", 32'(reg_write_data), 16'hBEEF);
        check("r0_retire", 32'(retire_count), 3);

        // Load to r3, response on the third WAIT_LOAD cycle.
        load_start(3'd3);
        for (int i = 0; i < 3; i++) begin
            check("ld3_ready", 32'(wb_ready), 0);
            check("ld3_pend", 32'(load_pending), 1);
            check("ld3_padd", 32'(pending_add), 3);
            check("ld3_wen", 32'(write_EN), 0);
            if (i < 2) tick();
        end
        load_resp(3'd3, 16'h00A5);
        check("ld3_ready_back", 32'(wb_ready), 1);
        check("ld3_pend_off", 32'(load_pending), 0);
        check("ld3_padd_off", 32'(pending_add), 0);
        check("ld3_retire", 32'(retire_count), exp_retire);

        // Load to r5: stray valid in the accept cycle is ignored; real
        // response lands on the 15th (final) WAIT_LOAD cycle and wins.
        mem_rdata_valid = 1'b1; mem_rdata = 16'hDEAD;
        load_start(3'd5);
        mem_rdata_valid = 1'b0;
        check("ld5_ready", 32'(wb_ready), 0);
        repeat (14) tick();
        check("ld5_pend_last", 32'(load_pending), 1);
        load_resp(3'd5, 16'h5A5A);
        check("ld5_tmo", 32'(load_timeout), 0);
        check("ld5_ready_back", 32'(wb_ready), 1);
        check("ld5_retire", 32'(retire_count), exp_retire);

        // Load to r4 with no response: exactly 15 WAIT_LOAD cycles.
        load_start(3'd4);
        for (int i = 0; i < 15; i++) begin
            check("ld4_pend", 32'(load_pending), 1);
            check("ld4_tmo_early", 32'(load_timeout), 0);
            tick();
        end
        check("ld4_pend_off", 32'(load_pending), 0);
        check("ld4_tmo", 32'(load_timeout), 1);
        check("ld4_retire", 32'(retire_count), exp_retire);
        alu(3'd6, 16'h0BAD);
        check("post_tmo_wen", 32'(write_EN), 1);
        check("post_tmo_retire", 32'(retire_count), exp_retire);
        check("tmo_sticky", 32'(load_timeout), 1);

        // Load to r0: waits and consumes its response, writes nothing.
        load_start(3'd0);
        check("ld0_padd", 32'(pending_add), 0);
        check("ld0_pend", 32'(load_pending), 1);
        tick();
        load_resp(3'd0, 16'h7777);
        check("ld0_wen", 32'(write_EN), 0);
        check("ld0_ready", 32'(wb_ready), 1);
        check("ld0_retire", 32'(retire_count), exp_retire);

        // Reset in the 2nd WAIT_LOAD cycle, then a late valid in IDLE.
        load_start(3'd7);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_retire = 0;
        mem_rdata_valid = 1'b1; mem_rdata = 16'h4321;
        tick();
        mem_rdata_valid = 1'b0;
        check_reset_state("rst_wait");
        tick();
        check("late_valid_wen", 32'(write_EN), 0);

        check("sb_empty", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

MEM/WB writeback stage of the 16-bit MIPS pipeline, and the sole driver of the register file write port.
- Accepts one retiring instruction per cycle from the MEM stage and selects the ALU result or the load data.
- Stalls the pipeline while a load response is outstanding, then issues a single registered write (enable, 3-bit address, 16-bit data).
- Exposes a pending-load indication for the hazard unit and keeps a retired-instruction counter.

## Interface
Parameters:
- DATA_W, 16, register/data width
- ADDR_W, 3, register address width (8 registers)
- ZERO_PROTECT, 1, when 1 writes to r0 are suppressed
- LOAD_TIMEOUT, 15, maximum cycles spent in WAIT_LOAD (≥1)
- CNT_W, 16, retire counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- wb_valid  in  1  MEM stage presents an instruction
- wb_ready  out  1  unit can accept (combinational: 1 in IDLE, 0 in WAIT_LOAD)
- wb_reg_write  in  1  instruction writes a register
- wb_mem_to_reg  in  1  result comes from data memory (load)
- wb_dest  in  ADDR_W  destination register
- wb_alu_result  in  DATA_W  ALU result
- mem_rdata_valid  in  1  load data valid (one-cycle pulse)
- mem_rdata  in  DATA_W  load data
- write_EN  out  1  register file write enable (registered)
- reg_write_add  out  ADDR_W  write address (registered)
- reg_write_data  out  DATA_W  write data (registered)
- load_pending  out  1  high in WAIT_LOAD
- pending_add  out  ADDR_W  destination of the outstanding load (0 when idle)
- retire_count  out  CNT_W  instructions retired, wraps
- load_timeout  out  1  sticky error: a load response never arrived

## Operation
Handshake:
- An instruction is accepted on a rising edge where wb_valid and wb_ready are both 1.
- The MEM stage holds its fields stable while wb_ready is 0.

Write suppression:
- "wr_ok" = wb_reg_write and not (ZERO_PROTECT and dest==0).

States:
- IDLE, accept with wb_reg_write=0: no write; retire_count+1; stay IDLE.
- IDLE, accept non-load (wb_mem_to_reg=0): write_EN=wr_ok next cycle, with address wb_dest and data wb_alu_result; retire_count+1; stay IDLE. Back-to-back accepts give one write per cycle.
- IDLE, accept load (wb_mem_to_reg=1, wb_reg_write=1): latch dest and wr_ok; clear the timeout counter; go to WAIT_LOAD. write_EN=0 next cycle.
- WAIT_LOAD, mem_rdata_valid=1: write_EN=latched wr_ok next cycle, with latched dest and mem_rdata; retire_count+1; return to IDLE.
- WAIT_LOAD, no valid: the timeout counter increments. A cycle with counter == LOAD_TIMEOUT-1 and no valid sets load_timeout and returns to IDLE. The load is dropped with no write and no retire increment.

Boundary conditions:
- Valid arriving on the final timeout cycle wins over the timeout.
- mem_rdata_valid in IDLE is ignored, including in the acceptance cycle of a load; data is sampled only in WAIT_LOAD.
- A load to r0 with ZERO_PROTECT=1 still waits for and consumes its response, but writes nothing.
- load_timeout clears only on rst.
- retire_count wraps from 2^CNT_W-1 to 0.
- write_EN is high for exactly one cycle per write. Address and data hold their last values when write_EN=0.

## Timing
- Reset, synchronous: state IDLE; write_EN=0, reg_write_add=0, reg_write_data=0, pending_add=0, load_pending=0, retire_count=0, load_timeout=0, timeout counter=0.
- Reset during WAIT_LOAD abandons the load with no write.
- Non-load latency: accept at edge N → write_EN high during cycle N+1 → register file updated at edge N+1.
- Load latency: data valid at edge M → write_EN during cycle M+1. wb_ready rises in cycle M+1, so the next accept is at edge M+1 at the earliest.
- load_pending and pending_add are valid from the cycle after load acceptance through the cycle in which data or timeout is sampled.

## Test plan
- Reset, then accept ALU writes r1=0x1234 and r2=0xBEEF on consecutive edges → write_EN high two cycles with (1,0x1234) then (2,0xBEEF); retire_count=2.
- Accept an ALU write to r0 of 0x5555 with ZERO_PROTECT=1 → write_EN stays 0; retire_count increments.
- Load to r3, mem_rdata_valid=0x00A5 three cycles later → wb_ready=0 and load_pending=1 with pending_add=3 for 3 cycles; one write (3,0x00A5); wb_ready returns to 1.
- Load to r4 with no response → after 15 WAIT_LOAD cycles load_timeout=1, no write, retire_count unchanged. Next ALU instruction proceeds normally.
- Load to r5 with valid on the 15th cycle → write (5,data); load_timeout stays 0.
- rst asserted in the 2nd WAIT_LOAD cycle, followed by a late valid → no write; all outputs at reset values; the late valid is ignored in IDLE.
